dot_product_bfp_accum: RTL and testbench

//  Streaming dot-product engine: one element pair (v1[i], v2[i]) in half-precision-style

---
 rtl/dot_product_bfp_accum_pkg.sv | 42 ++++
 rtl/dot_product_bfp_accum_if.sv | 13 +
 rtl/dot_product_bfp_accum_align_add.sv | 66 ++++++
 rtl/dot_product_bfp_accum.sv | 65 ++++++
 tb/tb_dot_product_bfp_accum.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_product_bfp_accum_pkg.sv
// Shared widths, biases and record types for the half-precision dot-product
// engine with a block-floating-point accumulator.
package dot_product_bfp_accum_pkg;

  localparam int IN_W      = 16;
  localparam int EXP_W     = 5;
  localparam int MAN_W     = 10;
  localparam int OUT_W     = 32;
  localparam int IN_BIAS   = 15;
  localparam int OUT_BIAS  = 127;
  localparam int ACC_FRAC  = 20;
  localparam int ACC_EXP_W = 10;

  localparam logic [OUT_W-1:0] SAT_MAG = 32'h7F7F_FFFF;

  typedef struct packed {
    logic                        sign;
    logic                        zero;
    logic signed [ACC_EXP_W-1:0] exp;
    logic [MAN_W:0]              man;
  } operand_t;

  // Q1.20 magnitude with the leading one implied whenever zero is clear.
  typedef struct packed {
    logic                        sign;
    logic                        zero;
    logic signed [ACC_EXP_W-1:0] exp;
    logic [ACC_FRAC-1:0]         frac;
  } bfp_t;

  localparam bfp_t BFP_ZERO = '{sign: 1'b0, zero: 1'b1, exp: '0, frac: '0};

  function automatic operand_t decode(input logic [IN_W-1:0] x);
    operand_t o;
    o.sign = x[IN_W-1];
    o.zero = (x[IN_W-2 -: EXP_W] == '0);
    o.exp  = ACC_EXP_W'(x[IN_W-2 -: EXP_W]) - ACC_EXP_W'(IN_BIAS);
    o.man  = {1'b1, x[MAN_W-1:0]};
    return o;
  endfunction

endpackage

// File: rtl/dot_product_bfp_accum_if.sv
// Element-pair stream into the dot-product engine and its running result.
interface dot_product_bfp_accum_if;
  import dot_product_bfp_accum_pkg::*;

  logic             enable;
  logic [IN_W-1:0]  v1;
  logic [IN_W-1:0]  v2;
  logic [OUT_W-1:0] final_result;

  modport master (output enable, v1, v2, input final_result);
  modport slave  (input enable, v1, v2, output final_result);

endinterface

// File: rtl/dot_product_bfp_accum_align_add.sv
// Combinational block-floating-point add: align to the larger exponent,
// signed add, then renormalise so the leading one lands at bit 20.
module bfp_align_add
  import dot_product_bfp_accum_pkg::*;
(
  input  bfp_t a_i,
  input  bfp_t b_i,
  output bfp_t sum_o
);

  logic                        big_sign, small_sign;
  logic signed [ACC_EXP_W-1:0] big_exp, small_exp;
  logic [ACC_FRAC-1:0]         big_frac, small_frac;
  logic [ACC_EXP_W:0]          diff;
  logic [ACC_FRAC:0]           small_mag;
  logic signed [ACC_FRAC+2:0]  big_s, small_s, sum_s;
  logic [ACC_FRAC+1:0]         mag;
  logic [4:0]                  lz;

  always_comb begin
    big_sign   = a_i.sign;
    big_exp    = a_i.exp;
    big_frac   = a_i.frac;
    small_sign = b_i.sign;
    small_exp  = b_i.exp;
    small_frac = b_i.frac;
    if ($signed(b_i.exp) > $signed(a_i.exp)) begin
      big_sign   = b_i.sign;
      big_exp    = b_i.exp;
      big_frac   = b_i.frac;
      small_sign = a_i.sign;
      small_exp  = a_i.exp;
      small_frac = a_i.frac;
    end

    diff      = {big_exp[ACC_EXP_W-1], big_exp} - {small_exp[ACC_EXP_W-1], small_exp};
    small_mag = (diff >= (ACC_EXP_W+1)'(24)) ? '0 : ({1'b1, small_frac} >> diff[4:0]);

    big_s   = {2'b00, 1'b1, big_frac};
    small_s = {2'b00, small_mag};
    if (big_sign)   big_s   = -big_s;
    if (small_sign) small_s = -small_s;
    sum_s = big_s + small_s;
    mag   = (ACC_FRAC+2)'(sum_s[ACC_FRAC+2] ? -sum_s : sum_s);

    // Distance from the highest set bit below the carry bit up to bit 20.
    lz = '0;
    for (int i = 0; i <= ACC_FRAC; i++) begin
      if (mag[i]) lz = 5'(ACC_FRAC - i);
    end

    sum_o.sign = sum_s[ACC_FRAC+2];
    sum_o.zero = (mag == '0);
    if (mag[ACC_FRAC+1]) begin
      sum_o.exp  = big_exp + ACC_EXP_W'(1);
      sum_o.frac = mag[ACC_FRAC:1];
    end else begin
      sum_o.exp  = big_exp - $signed({5'b0, lz});
      sum_o.frac = ACC_FRAC'(mag << lz);
    end

    if (a_i.zero)      sum_o = b_i;
    else if (b_i.zero) sum_o = a_i;
  end

endmodule

// File: rtl/dot_product_bfp_accum.sv
// Streaming half-precision dot product: multiply stage, BFP accumulate stage,
// and an IEEE single-precision output register.
module dot_product_bfp_accum
  import dot_product_bfp_accum_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  dot_product_bfp_accum_if.slave bus_if
);

  operand_t           op1, op2;
  logic [2*MAN_W+1:0] prod_raw;
  bfp_t               prod_d, prod_p1_q, sum_p1, acc_p2_q;
  logic               vld_p1_q;
  logic [OUT_W-1:0]   result_p3_q;

  function automatic logic [OUT_W-1:0] pack_single(input bfp_t a);
    logic signed [ACC_EXP_W:0] biased;
    biased = {a.exp[ACC_EXP_W-1], a.exp} + (ACC_EXP_W+1)'(OUT_BIAS);
    if (a.zero || biased < 11'sd1) return '0;
    if (biased > 11'sd254)         return {a.sign, SAT_MAG[OUT_W-2:0]};
    return {a.sign, biased[7:0], a.frac, 3'b000};
  endfunction

  always_comb begin
    op1         = decode(bus_if.v1);
    op2         = decode(bus_if.v2);
    prod_raw    = {11'd0, op1.man} * {11'd0, op2.man};
    prod_d.sign = op1.sign ^ op2.sign;
    prod_d.zero = op1.zero | op2.zero;
    prod_d.exp  = op1.exp + op2.exp + ACC_EXP_W'(prod_raw[2*MAN_W+1]);
    prod_d.frac = prod_raw[2*MAN_W+1] ? prod_raw[2*MAN_W:1] : prod_raw[2*MAN_W-1:0];
  end

  // p1: registered product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      prod_p1_q <= BFP_ZERO;
    end else begin
      vld_p1_q <= bus_if.enable;
      if (bus_if.enable) prod_p1_q <= prod_d;
    end
  end

  bfp_align_add u_align_add (
    .a_i   (acc_p2_q),
    .b_i   (prod_p1_q),
    .sum_o (sum_p1)
  );

  // p2: accumulator; p3: packed single-precision result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p2_q    <= BFP_ZERO;
      result_p3_q <= '0;
    end else begin
      if (vld_p1_q) acc_p2_q <= sum_p1;
      result_p3_q <= pack_single(acc_p2_q);
    end
  end

  assign bus_if.final_result = result_p3_q;

endmodule

// File: tb/tb_dot_product_bfp_accum.sv
// Bench for dot_product_bfp_accum: directed scenarios plus random streams
// compared against an arithmetic model of the accumulation rules.
module tb_dot_product_bfp_accum;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          e;
  } pair_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   edge_cnt;
  pair_t q[$];

  bit          m_zero;
  bit          m_sign;
  int          m_exp;
  longint      m_mag;
  logic [31:0] exp_res;
  logic [31:0] held;

  dot_product_bfp_accum_if bus();

  dot_product_bfp_accum dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Running sum kept as signed magnitude m * 2^(exp-20), 2^20 <= m < 2^21.
  function automatic void model_add(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, pe, be, d;
    longint p, ps, acc_v, big_v, small_v, s, mag;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 0 || eb == 0) return;
    p  = longint'({1'b1, a[9:0]}) * longint'({1'b1, b[9:0]});
    pe = ea + eb - 30;
    if (p >= 2**21) begin
      p  = p >> 1;
      pe = pe + 1;
    end
    ps = (a[15] ^ b[15]) ? -p : p;
    if (m_zero) begin
      m_zero = 0;
      m_sign = (ps < 0);
      m_mag  = p;
      m_exp  = pe;
      return;
    end
    acc_v = m_sign ? -m_mag : m_mag;
    if (m_exp >= pe) begin
      big_v = acc_v; small_v = ps; be = m_exp; d = m_exp - pe;
    end else begin
      big_v = ps; small_v = acc_v; be = pe; d = pe - m_exp;
    end
    mag     = (small_v < 0) ? -small_v : small_v;
    mag     = (d >= 24) ? 0 : (mag >> d);
    small_v = (small_v < 0) ? -mag : mag;
    s = big_v + small_v;
    if (s == 0) begin
      m_zero = 1;
      return;
    end
    m_sign = (s < 0);
    mag    = m_sign ? -s : s;
    if (mag >= 2**21) begin
      mag = mag >> 1;
      be  = be + 1;
    end
    while (mag < 2**20) begin
      mag = mag << 1;
      be  = be - 1;
    end
    m_mag = mag;
    m_exp = be;
  endfunction

  function automatic logic [31:0] model_pack();
    int be;
    be = m_exp + 127;
    if (m_zero || be < 1) return 32'h0;
    if (be > 254) return {m_sign, 31'h7F7FFFFF};
    return {m_sign, 8'(be), 20'(m_mag), 3'b000};
  endfunction

  function automatic logic [15:0] rand_half();
    logic [4:0] e;
    if ($urandom_range(0, 15) == 0)     e = 5'd0;
    else if ($urandom_range(0, 3) == 0) e = 5'($urandom_range(1, 31));
    else                                e = 5'($urandom_range(8, 22));
    return {1'($urandom_range(0, 1)), e, 10'($urandom)};
  endfunction

  // One clock: drive, take the edge, fold in every pair now two edges old.
  task automatic cycle(input bit en, input logic [15:0] a, input logic [15:0] b);
    bus.enable = en;
    bus.v1     = a;
    bus.v2     = b;
    @(posedge clk);
    edge_cnt++;
    if (en) q.push_back('{a: a, b: b, e: edge_cnt});
    while (q.size() > 0 && q[0].e <= edge_cnt - 2) begin
      model_add(q[0].a, q[0].b);
      void'(q.pop_front());
    end
    exp_res = model_pack();
    #1;
  endtask

  task automatic do_reset();
    bus.enable = 1'b0;
    rst = 1'b1;
    q.delete();
    m_zero  = 1;
    exp_res = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (bus.final_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_async got %h expected %h", bus.final_result, 32'h0);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 16'h3C00, 16'h3C00);
      checks++;
      if (bus.final_result !== 32'h0 || bus.final_result !== exp_res) begin
        errors++;
        $display("FAIL reset_idle[%0d] got %h expected %h", i, bus.final_result, 32'h0);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] want [4];
    logic [15:0] va   [4];
    logic [15:0] vb   [4];
    want = '{32'h0, 32'h0, 32'h40000000, 32'h40880000};
    va   = '{16'h3C00, 16'h3E00, 16'h0000, 16'h0000};
    vb   = '{16'h4000, 16'h3E00, 16'h0000, 16'h0000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(i < 2, va[i], vb[i]);
      checks++;
      if (bus.final_result !== want[i] || bus.final_result !== exp_res) begin
        errors++;
        $display("FAIL basic[%0d] got %h expected %h", i, bus.final_result, want[i]);
      end
    end
  endtask

  task automatic test_cancel();
    logic [31:0] want [4];
    want = '{32'h0, 32'h0, 32'h3F800000, 32'h00000000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      cycle(1'b1, 16'h3C00, 16'h3C00);
      else if (i == 1) cycle(1'b1, 16'hBC00, 16'h3C00);
      else             cycle(1'b0, 16'h0000, 16'h0000);
      checks++;
      if (bus.final_result !== want[i] || bus.final_result !== exp_res) begin
        errors++;
        $display("FAIL cancel[%0d] got %h expected %h", i, bus.final_result, want[i]);
      end
    end
  endtask

  task automatic test_tiny_operand(input logic [15:0] a, input logic [15:0] b);
    do_reset();
    cycle(1'b1, 16'h3C00, 16'h3C00);
    cycle(1'b1, a, b);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0000, 16'h0000);
      checks++;
      if (bus.final_result !== 32'h3F800000 || bus.final_result !== exp_res) begin
        errors++;
        $display("FAIL tiny_%h_%h[%0d] got %h expected %h", a, b, i, bus.final_result, 32'h3F800000);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    cycle(1'b1, 16'h3C00, 16'h3C00);
    cycle(1'b1, 16'h4000, 16'h3C00);
    cycle(1'b1, 16'h4000, 16'h4000);
    checks++;
    if (bus.final_result !== 32'h3F800000) begin
      errors++;
      $display("FAIL midrst_pre got %h expected %h", bus.final_result, 32'h3F800000);
    end
    #2;
    rst = 1'b1;
    q.delete();
    m_zero = 1;
    #1;
    checks++;
    if (bus.final_result !== 32'h0) begin
      errors++;
      $display("FAIL midrst_immediate got %h expected %h", bus.final_result, 32'h0);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h4000, 16'h4000);
      checks++;
      if (bus.final_result !== 32'h0 || bus.final_result !== exp_res) begin
        errors++;
        $display("FAIL midrst_after[%0d] got %h expected %h", i, bus.final_result, 32'h0);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    cycle(1'b1, 16'h3C00, 16'h4000);
    cycle(1'b1, 16'h3E00, 16'h3E00);
    cycle(1'b0, 16'h4000, 16'h4000);
    cycle(1'b0, 16'h4000, 16'h4000);
    held = bus.final_result;
    checks++;
    if (held !== 32'h40880000) begin
      errors++;
      $display("FAIL hold_start got %h expected %h", held, 32'h40880000);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h5555, 16'h4321);
      checks++;
      if (bus.final_result !== 32'h40880000 || bus.final_result !== exp_res) begin
        errors++;
        $display("FAIL hold[%0d] got %h expected %h", i, bus.final_result, 32'h40880000);
      end
    end
    cycle(1'b1, 16'h3C00, 16'h3C00);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 16'h0000, 16'h0000);
    end
    checks++;
    if (bus.final_result !== 32'h40A80000 || bus.final_result !== exp_res) begin
      errors++;
      $display("FAIL hold_resume got %h expected %h", bus.final_result, 32'h40A80000);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    bit          en;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      a  = rand_half();
      b  = rand_half();
      cycle(en, a, b);
      checks++;
      if (bus.final_result !== exp_res) begin
        errors++;
        $display("FAIL random[%0d] got %h expected %h", i, bus.final_result, exp_res);
      end
      if (i == 200) do_reset();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, rand_half(), rand_half());
      checks++;
      if (bus.final_result !== exp_res) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %h expected %h", i, bus.final_result, exp_res);
      end
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.v1     = '0;
    bus.v2     = '0;
    checks     = 0;
    errors     = 0;
    edge_cnt   = 0;
    m_zero     = 1;
    m_sign     = 0;
    m_exp      = 0;
    m_mag      = 0;
    exp_res    = '0;
    held       = '0;
    test_reset();
    test_basic();
    test_cancel();
    test_tiny_operand(16'h0001, 16'h3C00);
    test_tiny_operand(16'h0400, 16'h0400);
    test_reset_midstream();
    test_hold();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
